// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: frame-coherent shadow of the
// displayed digits, per-slot dead-time blanking and leading-zero suppression.
module display_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] digits_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    input  logic                lz_en,
    output logic [3:0]          bcd,
    output logic [DIGITS-1:0]   an,
    output logic                dp,
    output logic                pending,
    output logic                frame_done
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK);

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    logic [IW-1:0]       idx_reg;
    logic [IW-1:0]       idx_next;
    logic [CW-1:0]       cnt_reg;
    logic [CW-1:0]       cnt_next;
    logic [4*DIGITS-1:0] shadow_d_reg;
    logic [4*DIGITS-1:0] shadow_d_next;
    logic [DIGITS-1:0]   shadow_p_reg;
    logic [DIGITS-1:0]   shadow_p_next;
    logic [4*DIGITS-1:0] pend_d_reg;
    logic [DIGITS-1:0]   pend_p_reg;

    logic                slot_end;
    logic                frame_end;
    phase_t              phase_next;
    logic [DIGITS-1:0]   zero_from;
    logic                suppressed;
    logic                lit;
    logic [DIGITS-1:0]   an_next;
    logic                dp_next;
    logic                frame_done_next;
    logic [3:0]          dig_next [DIGITS];

    genvar gi;

    assign slot_end  = (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    always_comb begin
        cnt_next = slot_end ? '0 : cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (slot_end) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    // A load on the boundary edge is newer than anything pending, so it wins.
    always_comb begin
        shadow_d_next = shadow_d_reg;
        shadow_p_next = shadow_p_reg;
        if (frame_end && load) begin
            shadow_d_next = digits_in;
            shadow_p_next = dp_in;
        end else if (frame_end && pending) begin
            shadow_d_next = pend_d_reg;
            shadow_p_next = pend_p_reg;
        end
    end

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign dig_next[gi] = shadow_d_next[4*gi +: 4];
        end
    endgenerate

    // A zero is only "leading" if nothing at or above it is visible, dp included.
    always_comb begin
        logic acc;
        acc       = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc          = acc && (shadow_d_next[4*i +: 4] == 4'd0) && !shadow_p_next[i];
            zero_from[i] = acc;
        end
    end

    always_comb begin
        phase_next      = (cnt_next >= CNT_SHOW) ? PH_SHOW : PH_BLANK;
        suppressed      = lz_en && (idx_next != '0) && zero_from[idx_next];
        lit             = (phase_next == PH_SHOW) && !suppressed;
        dp_next         = lit && shadow_p_next[idx_next];
        frame_done_next = (idx_next == IDX_LAST) && (cnt_next == CNT_LAST);
        an_next         = '1;
        for (int i = 0; i < DIGITS; i++) begin
            an_next[i] = !(lit && (idx_next == IW'(i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg      <= '0;
            cnt_reg      <= '0;
            shadow_d_reg <= '0;
            shadow_p_reg <= '0;
            pend_d_reg   <= '0;
            pend_p_reg   <= '0;
            pending      <= 1'b0;
            an           <= '1;
            bcd          <= 4'd0;
            dp           <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            idx_reg      <= idx_next;
            cnt_reg      <= cnt_next;
            shadow_d_reg <= shadow_d_next;
            shadow_p_reg <= shadow_p_next;
            if (load && !frame_end) begin
                pend_d_reg <= digits_in;
                pend_p_reg <= dp_in;
                pending    <= 1'b1;
            end else if (frame_end) begin
                pending    <= 1'b0;
            end
            an         <= an_next;
            bcd        <= dig_next[idx_next];
            dp         <= dp_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK=2.
module tb_display_scan_ctrl;
    localparam int D = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        dp;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int t = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_en      (lz_en),
        .bcd        (bcd),
        .an         (an),
        .dp         (dp),
        .pending    (pending),
        .frame_done (frame_done)
    );

    task automatic tick();
        @(negedge clk);
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        lz_en = 1'b0;
        pulse_load(16'h1234, 4'b0100);
        run_to(18);
        pulse_load(16'h9999, 4'b0000);
        checks++;
        if (an !== 4'b1011) begin
            errors++; $display("FAIL pre_reset_an t=%0d got %b expected %b", t, an, 4'b1011);
        end
        checks++;
        if (pending !== 1'b1) begin
            errors++; $display("FAIL pre_reset_pending got %b expected 1", pending);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'b1111) begin
            errors++; $display("FAIL reset_an got %b expected 1111", an);
        end
        checks++;
        if (bcd !== 4'd0) begin
            errors++; $display("FAIL reset_bcd got %0d expected 0", bcd);
        end
        checks++;
        if (dp !== 1'b0) begin
            errors++; $display("FAIL reset_dp got %b expected 0", dp);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++; $display("FAIL reset_pending got %b expected 0", pending);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done got %b expected 0", frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        for (int i = 0; i < P; i++) begin
            logic [3:0] exp_an;
            exp_an = (i < B) ? 4'b1111 : 4'b1110;
            checks++;
            if (an !== exp_an) begin
                errors++; $display("FAIL post_reset_an t=%0d got %b expected %b", t, an, exp_an);
            end
            checks++;
            if (bcd !== 4'd0) begin
                errors++; $display("FAIL post_reset_bcd t=%0d got %0d expected 0", t, bcd);
            end
            tick();
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_scan();
        logic [3:0] bcd_tab [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        apply_reset();
        lz_en = 1'b0;
        pulse_load(16'h1234, 4'b0100);
        checks++;
        if (pending !== 1'b1) begin
            errors++; $display("FAIL basic_pending_rise got %b expected 1", pending);
        end
        run_to(30);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL basic_fd_early got %b expected 0", frame_done);
        end
        tick();
        checks++;
        if (frame_done !== 1'b1 || pending !== 1'b1) begin
            errors++; $display("FAIL basic_fd_cycle got fd=%b pend=%b expected fd=1 pend=1", frame_done, pending);
        end
        tick();
        checks++;
        if (pending !== 1'b0) begin
            errors++; $display("FAIL basic_pending_fall got %b expected 0", pending);
        end
        while (t < 96) begin
            int s;
            int c;
            logic [3:0] exp_an;
            logic exp_dp;
            logic exp_fd;
            s      = (t / P) % D;
            c      = t % P;
            exp_an = (c < B) ? 4'b1111 : an_tab[s];
            exp_dp = (s == 2) && (c >= B);
            exp_fd = (t % (D * P)) == (D * P - 1);
            checks++;
            if (bcd !== bcd_tab[s]) begin
                errors++; $display("FAIL basic_bcd t=%0d got %0d expected %0d", t, bcd, bcd_tab[s]);
            end
            checks++;
            if (an !== exp_an) begin
                errors++; $display("FAIL basic_an t=%0d got %b expected %b", t, an, exp_an);
            end
            checks++;
            if (dp !== exp_dp) begin
                errors++; $display("FAIL basic_dp t=%0d got %b expected %b", t, dp, exp_dp);
            end
            checks++;
            if (frame_done !== exp_fd) begin
                errors++; $display("FAIL basic_frame_done t=%0d got %b expected %b", t, frame_done, exp_fd);
            end
            tick();
        end
        $display("test_basic_scan done");
    endtask

    task automatic test_frame_coherence();
        logic [3:0] old_tab [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        apply_reset();
        lz_en = 1'b0;
        pulse_load(16'h1234, 4'b0100);
        run_to(43);
        pulse_load(16'h5678, 4'b0000);
        while (t < 64) begin
            int s;
            s = (t / P) % D;
            checks++;
            if (bcd !== old_tab[s]) begin
                errors++; $display("FAIL coherence_old_bcd t=%0d got %0d expected %0d", t, bcd, old_tab[s]);
            end
            checks++;
            if (pending !== 1'b1) begin
                errors++; $display("FAIL coherence_pending t=%0d got %b expected 1", t, pending);
            end
            tick();
        end
        checks++;
        if (pending !== 1'b0 || bcd !== 4'd8) begin
            errors++; $display("FAIL coherence_switch got pend=%b bcd=%0d expected pend=0 bcd=8", pending, bcd);
        end
        run_to(74);
        checks++;
        if (bcd !== 4'd7 || an !== 4'b1101) begin
            errors++; $display("FAIL coherence_slot1 got bcd=%0d an=%b expected bcd=7 an=1101", bcd, an);
        end
        $display("test_frame_coherence done");
    endtask

    task automatic test_load_collision();
        apply_reset();
        lz_en = 1'b0;
        run_to(5);
        pulse_load(16'h1111, 4'b0000);
        run_to(20);
        pulse_load(16'h2222, 4'b0000);
        run_to(32);
        while (t < 63) begin
            checks++;
            if (bcd !== 4'd2) begin
                errors++; $display("FAIL collision_last_wins t=%0d got %0d expected 2", t, bcd);
            end
            tick();
        end
        checks++;
        if (frame_done !== 1'b1 || pending !== 1'b0) begin
            errors++; $display("FAIL collision_boundary got fd=%b pend=%b expected fd=1 pend=0", frame_done, pending);
        end
        pulse_load(16'h3333, 4'b0000);
        checks++;
        if (pending !== 1'b0 || bcd !== 4'd3) begin
            errors++; $display("FAIL collision_direct got pend=%b bcd=%0d expected pend=0 bcd=3", pending, bcd);
        end
        tick();
        checks++;
        if (pending !== 1'b0) begin
            errors++; $display("FAIL collision_pend_stays got %b expected 0", pending);
        end
        $display("test_load_collision done");
    endtask

    task automatic test_lz_suppress();
        apply_reset();
        lz_en = 1'b1;
        pulse_load(16'h0040, 4'b0000);
        run_to(32);
        while (t < 64) begin
            int s;
            int c;
            logic [3:0] exp_an;
            logic [3:0] exp_bcd;
            s       = (t / P) % D;
            c       = t % P;
            exp_bcd = (s == 1) ? 4'd4 : 4'd0;
            exp_an  = (c < B || s >= 2) ? 4'b1111 : ((s == 0) ? 4'b1110 : 4'b1101);
            checks++;
            if (an !== exp_an || bcd !== exp_bcd || dp !== 1'b0) begin
                errors++; $display("FAIL lz_0040 t=%0d got an=%b bcd=%0d dp=%b expected an=%b bcd=%0d dp=0",
                                   t, an, bcd, dp, exp_an, exp_bcd);
            end
            tick();
        end
        pulse_load(16'h0000, 4'b0000);
        run_to(96);
        while (t < 128) begin
            int s;
            int c;
            logic [3:0] exp_an;
            s      = (t / P) % D;
            c      = t % P;
            exp_an = (s == 0 && c >= B) ? 4'b1110 : 4'b1111;
            checks++;
            if (an !== exp_an || bcd !== 4'd0) begin
                errors++; $display("FAIL lz_0000 t=%0d got an=%b bcd=%0d expected an=%b bcd=0", t, an, bcd, exp_an);
            end
            tick();
        end
        lz_en = 1'b0;
        run_to(146);
        checks++;
        if (an !== 4'b1011) begin
            errors++; $display("FAIL lz_disabled got an=%b expected 1011", an);
        end
        $display("test_lz_suppress done");
    endtask

    task automatic test_invalid_bcd();
        logic [3:0] bcd_tab [4] = '{4'd0, 4'd15, 4'd0, 4'd0};
        logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        apply_reset();
        lz_en = 1'b1;
        pulse_load(16'h00F0, 4'b1000);
        run_to(32);
        while (t < 64) begin
            int s;
            int c;
            logic [3:0] exp_an;
            logic exp_dp;
            s      = (t / P) % D;
            c      = t % P;
            exp_an = (c < B) ? 4'b1111 : an_tab[s];
            exp_dp = (s == 3) && (c >= B);
            checks++;
            if (bcd !== bcd_tab[s] || an !== exp_an || dp !== exp_dp) begin
                errors++; $display("FAIL invalid_bcd t=%0d got bcd=%0d an=%b dp=%b expected bcd=%0d an=%b dp=%b",
                                   t, bcd, an, dp, bcd_tab[s], exp_an, exp_dp);
            end
            tick();
        end
        lz_en = 1'b0;
        $display("test_invalid_bcd done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        lz_en     = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        test_reset();
        test_basic_scan();
        test_frame_coherence();
        test_load_collision();
        test_lz_suppress();
        test_invalid_bcd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
